bubbledrive8_tempsense_multi: RTL and testbench

Multi-channel successor to the single-sensor bubble-memory temperature monitor. Polls CHANNELS TC77 sensors round-robin over a shared SIO/SCK bus with one chip-select per channel, and tracks per-channel readings and faults. Drives the cold-start hold (nTEMPLO / nLED_DELAYING) from the coldest healthy sensor and the fan from the hottest, with hysteresis. Sits beside the bubble controller and gates its start-up exactly as the single-channel block did.

---
 rtl/bubbledrive8_tempsense_multi_pkg.sv | 26 ++
 rtl/bubbledrive8_tempsense_multi_tc77_rx.sv | 105 ++++++++++
 rtl/bubbledrive8_tempsense_multi.sv | 151 +++++++++++++++
 tb/tb_bubbledrive8_tempsense_multi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bubbledrive8_tempsense_multi_pkg.sv
// Shared types and constants for the multi-channel TC77 temperature monitor.
package tempsense_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_CS_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_CS_HOLD,
    ST_EVAL
  } rxState_t;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned TEMP_W        = 13;
  localparam int unsigned TEMP_MSB      = 15;
  localparam int unsigned TEMP_LSB      = 3;
  localparam int unsigned DONE_BIT      = 2;
  localparam int unsigned BITS_PER_WORD = 16;
  localparam logic [WORD_W-1:0] BAD_WORD = 16'hFFFF;

  // Whole degrees C to the sensor's 1/16 degree code.
  function automatic logic signed [TEMP_W-1:0] celsiusToCode(input int unsigned degC);
    return $signed(TEMP_W'(degC << 4));
  endfunction

endpackage

// File: rtl/bubbledrive8_tempsense_multi_tc77_rx.sv
// TC77 bus master: poll gap, chip-select/SCK sequencing, 16-bit MSB-first shift, done pulse.
module tc77_rx
  import tempsense_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CLKDIV   = 24,
  parameter int unsigned POLL_GAP = 480000
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CHANNELS-1:0] chOneHot,
  input  logic                sio,
  output logic [CHANNELS-1:0] nCs,
  output logic                sck,
  output logic                done_c,
  output logic [WORD_W-1:0]   word
);

  localparam int unsigned CNT_MAX = (POLL_GAP > CLKDIV) ? POLL_GAP : CLKDIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(BITS_PER_WORD + 1);

  rxState_t          state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [BIT_W-1:0]  bitCnt, bitCntNext;
  logic [WORD_W-1:0] shiftReg, shiftNext;
  logic              rise;
  logic              cntZero;
  logic              csNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ST_GAP;
      cnt      <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      sck      <= 1'b0;
      nCs      <= '1;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      sck      <= (stateNext == ST_SCK_HI);
      nCs      <= csNext ? ~chOneHot : '1;
    end
  end

  // Every phase lasts until its down-counter reaches zero; SIO is captured on each SCK rise.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt - CNT_W'(1);
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    rise       = 1'b0;
    cntZero    = (cnt == '0);
    unique case (state)
      ST_GAP: if (cntZero) begin
        stateNext  = ST_CS_SETUP;
        cntNext    = CNT_W'(CLKDIV - 1);
        bitCntNext = '0;
        shiftNext  = '0;
      end
      ST_CS_SETUP: if (cntZero) begin
        stateNext = ST_SCK_HI;
        cntNext   = CNT_W'(CLKDIV - 1);
        rise      = 1'b1;
      end
      ST_SCK_HI: if (cntZero) begin
        stateNext = ST_SCK_LO;
        cntNext   = CNT_W'(CLKDIV - 1);
      end
      ST_SCK_LO: if (cntZero) begin
        cntNext = CNT_W'(CLKDIV - 1);
        if (bitCnt == BIT_W'(BITS_PER_WORD)) begin
          stateNext = ST_CS_HOLD;
        end else begin
          stateNext = ST_SCK_HI;
          rise      = 1'b1;
        end
      end
      ST_CS_HOLD: if (cntZero) begin
        stateNext = ST_EVAL;
        cntNext   = '0;
      end
      ST_EVAL: begin
        stateNext = ST_GAP;
        cntNext   = CNT_W'(POLL_GAP - 1);
      end
      default: begin
        stateNext = ST_GAP;
        cntNext   = '0;
      end
    endcase
    if (rise) begin
      bitCntNext = bitCnt + BIT_W'(1);
      shiftNext  = {shiftReg[WORD_W-2:0], sio};
    end
    csNext = stateNext inside {ST_CS_SETUP, ST_SCK_HI, ST_SCK_LO, ST_CS_HOLD};
    done_c = (state == ST_EVAL);
  end

  assign word = shiftReg;

endmodule

// File: rtl/bubbledrive8_tempsense_multi.sv
// Round-robin TC77 monitor: per-channel readings/faults, cold-start hold and fan control.
module bubbledrive8_tempsense_multi
  import tempsense_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CLKDIV      = 24,
  parameter int unsigned POLL_GAP    = 480000,
  parameter int unsigned FAN_ON_C    = 40,
  parameter int unsigned FAN_HYST_C  = 5,
  parameter int unsigned FAULT_LIMIT = 3
) (
  input  logic                MCLK,
  input  logic                nSYSOK,
  input  logic [2:0]          TEMPSW,
  input  logic                FORCESTART,
  output logic                nTEMPLO,
  output logic                nFANEN,
  output logic                nLED_DELAYING,
  output logic [CHANNELS-1:0] nTEMPCS,
  output logic                TEMPCLK,
  input  logic                TEMPSIO,
  output logic [TEMP_W-1:0]   TEMP_MAX,
  output logic [CHANNELS-1:0] FAULT
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned FC_W = $clog2(FAULT_LIMIT + 1);
  localparam logic signed [TEMP_W-1:0] FAN_ON_CODE  = celsiusToCode(FAN_ON_C);
  localparam logic signed [TEMP_W-1:0] FAN_OFF_CODE = celsiusToCode(FAN_ON_C - FAN_HYST_C);

  logic [2:0]                tempSwMeta, tempSwSync;
  logic                      forceMeta, forceSync;
  logic [CH_W-1:0]           channel;
  logic [CHANNELS-1:0]       chOneHot;
  logic                      rxDone;
  logic [WORD_W-1:0]         rxWord;

  logic signed [TEMP_W-1:0]  tempReg [CHANNELS];
  logic signed [TEMP_W-1:0]  tempNext [CHANNELS];
  logic [FC_W-1:0]           failCnt [CHANNELS];
  logic [FC_W-1:0]           failNext [CHANNELS];
  logic [CHANNELS-1:0]       fault, faultNext, valid, validNext;

  logic signed [TEMP_W-1:0]  tMax, tMin, tLoCode, tempMaxReg;
  logic                      badRead, anyHealthy, allCovered, allFaulted, coldOk;
  logic                      coldOkReg, nTempLoReg, nFanEnReg;

  tc77_rx #(
    .CHANNELS (CHANNELS),
    .CLKDIV   (CLKDIV),
    .POLL_GAP (POLL_GAP)
  ) rx (
    .clk      (MCLK),
    .rstN     (nSYSOK),
    .chOneHot (chOneHot),
    .sio      (TEMPSIO),
    .nCs      (nTEMPCS),
    .sck      (TEMPCLK),
    .done_c   (rxDone),
    .word     (rxWord)
  );

  always_comb begin
    chOneHot          = '0;
    chOneHot[channel] = 1'b1;
  end

  // Apply the finished read to the channel tables, then reduce over the healthy set.
  always_comb begin
    tempNext  = tempReg;
    failNext  = failCnt;
    faultNext = fault;
    validNext = valid;
    badRead   = !rxWord[DONE_BIT] || (rxWord == BAD_WORD);
    if (rxDone) begin
      if (badRead) begin
        if (failCnt[channel] < FC_W'(FAULT_LIMIT)) failNext[channel] = failCnt[channel] + FC_W'(1);
        if (failNext[channel] == FC_W'(FAULT_LIMIT)) faultNext[channel] = 1'b1;
      end else begin
        tempNext[channel]  = $signed(rxWord[TEMP_MSB:TEMP_LSB]);
        failNext[channel]  = '0;
        faultNext[channel] = 1'b0;
        validNext[channel] = 1'b1;
      end
    end
    anyHealthy = 1'b0;
    allCovered = 1'b1;
    tMax       = '0;
    tMin       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!faultNext[i] && !validNext[i]) allCovered = 1'b0;
      if (validNext[i] && !faultNext[i]) begin
        if (!anyHealthy || tempNext[i] > tMax) tMax = tempNext[i];
        if (!anyHealthy || tempNext[i] < tMin) tMin = tempNext[i];
        anyHealthy = 1'b1;
      end
    end
    allFaulted = &faultNext;
    tLoCode    = celsiusToCode(32'd10 + 32'd5 * 32'(tempSwSync));
    coldOk     = allFaulted || (allCovered && (tMin >= tLoCode));
  end

  always_ff @(posedge MCLK or negedge nSYSOK) begin
    if (!nSYSOK) begin
      tempSwMeta <= '0;
      tempSwSync <= '0;
      forceMeta  <= 1'b0;
      forceSync  <= 1'b0;
      channel    <= '0;
      fault      <= '0;
      valid      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        tempReg[i] <= '0;
        failCnt[i] <= '0;
      end
      tempMaxReg <= '0;
      coldOkReg  <= 1'b0;
      nTempLoReg <= 1'b0;
      nFanEnReg  <= 1'b1;
    end else begin
      tempSwMeta <= TEMPSW;
      tempSwSync <= tempSwMeta;
      forceMeta  <= FORCESTART;
      forceSync  <= forceMeta;
      tempReg    <= tempNext;
      failCnt    <= failNext;
      fault      <= faultNext;
      valid      <= validNext;
      if (rxDone) begin
        coldOkReg <= coldOk;
        channel   <= (channel == CH_W'(CHANNELS - 1)) ? '0 : channel + CH_W'(1);
        if (anyHealthy) tempMaxReg <= tMax;
        // With no usable sensor the fan runs; otherwise hysteresis between the two thresholds.
        if (allFaulted) begin
          nFanEnReg <= 1'b0;
        end else if (anyHealthy) begin
          if (tMax >= FAN_ON_CODE) nFanEnReg <= 1'b0;
          else if (tMax < FAN_OFF_CODE) nFanEnReg <= 1'b1;
        end
      end
      nTempLoReg <= forceSync || (rxDone ? coldOk : coldOkReg);
    end
  end

  assign nTEMPLO       = nTempLoReg;
  assign nLED_DELAYING = nTempLoReg;
  assign nFANEN        = nFanEnReg;
  assign TEMP_MAX      = tempMaxReg;
  assign FAULT         = fault;

endmodule

// File: tb/tb_bubbledrive8_tempsense_multi.sv
// Directed bench for the two-channel TC77 monitor with behavioural sensors on the shared bus.
module tb_bubbledrive8_tempsense_multi;

  logic        MCLK = 1'b0;
  logic        nSYSOK;
  logic [2:0]  TEMPSW;
  logic        FORCESTART;
  logic        nTEMPLO, nFANEN, nLED_DELAYING, TEMPCLK;
  logic [1:0]  nTEMPCS;
  logic        sio = 1'b1;
  logic [12:0] TEMP_MAX;
  logic [1:0]  FAULT;

  int checks = 0;
  int errors = 0;

  logic [15:0] sensorWord [2];
  logic [15:0] txShift = 16'hFFFF;
  logic [1:0]  csSeen = 2'b11;
  logic        clkSeen = 1'b0;

  bubbledrive8_tempsense_multi #(
    .CHANNELS (2),
    .CLKDIV   (2),
    .POLL_GAP (4)
  ) dut (
    .MCLK          (MCLK),
    .nSYSOK        (nSYSOK),
    .TEMPSW        (TEMPSW),
    .FORCESTART    (FORCESTART),
    .nTEMPLO       (nTEMPLO),
    .nFANEN        (nFANEN),
    .nLED_DELAYING (nLED_DELAYING),
    .nTEMPCS       (nTEMPCS),
    .TEMPCLK       (TEMPCLK),
    .TEMPSIO       (sio),
    .TEMP_MAX      (TEMP_MAX),
    .FAULT         (FAULT)
  );

  always #5 MCLK = ~MCLK;

  // Sensor: loads its word on chip-select fall, presents MSB, shifts on each SCK fall.
  always @(nTEMPCS or TEMPCLK) begin
    if (nTEMPCS != csSeen && nTEMPCS == 2'b10) begin
      txShift = sensorWord[0];
      sio     = txShift[15];
    end else if (nTEMPCS != csSeen && nTEMPCS == 2'b01) begin
      txShift = sensorWord[1];
      sio     = txShift[15];
    end else if (clkSeen && !TEMPCLK && nTEMPCS != 2'b11) begin
      txShift = {txShift[14:0], 1'b1};
      sio     = txShift[15];
    end
    csSeen  = nTEMPCS;
    clkSeen = TEMPCLK;
  end

  function automatic logic [15:0] mkWord(input int degC, input logic done);
    return {13'(degC * 16), done, 2'b00};
  endfunction

  // Wait for n transactions to end, then one more edge for the registered outputs.
  task automatic waitTxn(input int n);
    int seen;
    int cyc;
    logic [1:0] prev;
    seen = 0;
    cyc  = 0;
    prev = nTEMPCS;
    while (seen < n && cyc < n * 200) begin
      @(posedge MCLK); #1;
      cyc++;
      if (prev != 2'b11 && nTEMPCS == 2'b11) seen++;
      prev = nTEMPCS;
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL txn_timeout: saw %0d transactions, required %0d", seen, n);
    end
    @(posedge MCLK); #1;
  endtask

  task automatic test_reset();
    nSYSOK = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    checks++; if (nTEMPCS !== 2'b11) begin errors++; $display("FAIL rst_cs: got %b want 11", nTEMPCS); end
    checks++; if (TEMPCLK !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b want 0", TEMPCLK); end
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL rst_templo: got %b want 0", nTEMPLO); end
    checks++; if (nLED_DELAYING !== 1'b0) begin errors++; $display("FAIL rst_led: got %b want 0", nLED_DELAYING); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL rst_fan: got %b want 1", nFANEN); end
    checks++; if (TEMP_MAX !== 13'h000) begin errors++; $display("FAIL rst_tmax: got %h want 000", TEMP_MAX); end
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL rst_fault: got %b want 00", FAULT); end
    nSYSOK = 1'b1;
  endtask

  task automatic test_first_reads();
    waitTxn(1);
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL first_ch0_templo: got %b want 0", nTEMPLO); end
    checks++; if (TEMP_MAX !== 13'h190) begin errors++; $display("FAIL first_ch0_tmax: got %h want 190", TEMP_MAX); end
    waitTxn(1);
    checks++; if (nTEMPLO !== 1'b1) begin errors++; $display("FAIL first_both_templo: got %b want 1", nTEMPLO); end
    checks++; if (nLED_DELAYING !== 1'b1) begin errors++; $display("FAIL first_both_led: got %b want 1", nLED_DELAYING); end
    checks++; if (TEMP_MAX !== 13'h1E0) begin errors++; $display("FAIL first_both_tmax: got %h want 1E0", TEMP_MAX); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL first_both_fan: got %b want 1", nFANEN); end
  endtask

  task automatic test_fan_hysteresis();
    int          ramp   [6] = '{38, 40, 41, 37, 35, 34};
    logic [12:0] expMax [6] = '{13'h260, 13'h280, 13'h290, 13'h250, 13'h230, 13'h220};
    logic        expFan [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      sensorWord[1] = mkWord(ramp[i], 1'b1);
      waitTxn(2);
      checks++;
      if (nFANEN !== expFan[i]) begin
        errors++; $display("FAIL fan_%0dC: nFANEN got %b want %b", ramp[i], nFANEN, expFan[i]);
      end
      checks++;
      if (TEMP_MAX !== expMax[i]) begin
        errors++; $display("FAIL fan_tmax_%0dC: got %h want %h", ramp[i], TEMP_MAX, expMax[i]);
      end
    end
  endtask

  task automatic test_fault();
    TEMPSW        = 3'd4;
    sensorWord[0] = mkWord(25, 1'b0);
    waitTxn(2);
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL fault_bad1: got %b want 00", FAULT); end
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL fault_bad1_templo: got %b want 0", nTEMPLO); end
    waitTxn(2);
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL fault_bad2: got %b want 00", FAULT); end
    waitTxn(1);
    checks++; if (FAULT !== 2'b01) begin errors++; $display("FAIL fault_bad3: got %b want 01", FAULT); end
    checks++; if (nTEMPLO !== 1'b1) begin errors++; $display("FAIL fault_ch1only_templo: got %b want 1", nTEMPLO); end
    checks++; if (TEMP_MAX !== 13'h220) begin errors++; $display("FAIL fault_ch1only_tmax: got %h want 220", TEMP_MAX); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL fault_ch1only_fan: got %b want 1", nFANEN); end
    sensorWord[0] = mkWord(20, 1'b1);
    waitTxn(2);
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL fault_clear: got %b want 00", FAULT); end
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL fault_clear_templo: got %b want 0", nTEMPLO); end
  endtask

  task automatic test_all_float();
    sensorWord[0] = 16'hFFFF;
    sensorWord[1] = 16'hFFFF;
    waitTxn(5);
    checks++; if (FAULT !== 2'b10) begin errors++; $display("FAIL float_partial: got %b want 10", FAULT); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL float_partial_fan: got %b want 1", nFANEN); end
    waitTxn(1);
    checks++; if (FAULT !== 2'b11) begin errors++; $display("FAIL float_all: got %b want 11", FAULT); end
    checks++; if (nTEMPLO !== 1'b1) begin errors++; $display("FAIL float_templo: got %b want 1", nTEMPLO); end
    checks++; if (nLED_DELAYING !== 1'b1) begin errors++; $display("FAIL float_led: got %b want 1", nLED_DELAYING); end
    checks++; if (nFANEN !== 1'b0) begin errors++; $display("FAIL float_fan: got %b want 0", nFANEN); end
    sensorWord[0] = mkWord(5, 1'b1);
    sensorWord[1] = mkWord(5, 1'b1);
    waitTxn(2);
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL cold_fault: got %b want 00", FAULT); end
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL cold_templo: got %b want 0", nTEMPLO); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL cold_fan: got %b want 1", nFANEN); end
    checks++; if (TEMP_MAX !== 13'h050) begin errors++; $display("FAIL cold_tmax: got %h want 050", TEMP_MAX); end
  endtask

  task automatic test_force_start();
    FORCESTART = 1'b1;
    repeat (3) @(posedge MCLK);
    #1;
    checks++; if (nTEMPLO !== 1'b1) begin errors++; $display("FAIL force_on_templo: got %b want 1", nTEMPLO); end
    checks++; if (nLED_DELAYING !== 1'b1) begin errors++; $display("FAIL force_on_led: got %b want 1", nLED_DELAYING); end
    FORCESTART = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL force_off_templo: got %b want 0", nTEMPLO); end
    checks++; if (nLED_DELAYING !== 1'b0) begin errors++; $display("FAIL force_off_led: got %b want 0", nLED_DELAYING); end
  endtask

  task automatic test_reset_mid_shift();
    int   rises;
    int   cyc;
    logic prevClk;
    TEMPSW        = 3'd2;
    sensorWord[0] = mkWord(30, 1'b1);
    sensorWord[1] = mkWord(22, 1'b1);
    rises   = 0;
    cyc     = 0;
    prevClk = TEMPCLK;
    while (rises < 5 && cyc < 400) begin
      @(posedge MCLK); #1;
      cyc++;
      if (TEMPCLK && !prevClk) rises++;
      prevClk = TEMPCLK;
    end
    checks++; if (nTEMPCS === 2'b11) begin errors++; $display("FAIL mid_cs_active: got %b want one low", nTEMPCS); end
    nSYSOK = 1'b0;
    #1;
    checks++; if (nTEMPCS !== 2'b11) begin errors++; $display("FAIL mid_rst_cs: got %b want 11", nTEMPCS); end
    checks++; if (TEMPCLK !== 1'b0) begin errors++; $display("FAIL mid_rst_sck: got %b want 0", TEMPCLK); end
    checks++; if (TEMP_MAX !== 13'h000) begin errors++; $display("FAIL mid_rst_tmax: got %h want 000", TEMP_MAX); end
    checks++; if (nFANEN !== 1'b1) begin errors++; $display("FAIL mid_rst_fan: got %b want 1", nFANEN); end
    repeat (2) @(posedge MCLK);
    #1;
    nSYSOK = 1'b1;
    cyc = 0;
    while (nTEMPCS === 2'b11 && cyc < 20) begin
      @(posedge MCLK); #1;
      cyc++;
    end
    checks++; if (nTEMPCS !== 2'b10) begin errors++; $display("FAIL restart_ch0_cs: got %b want 10", nTEMPCS); end
    waitTxn(1);
    checks++; if (nTEMPLO !== 1'b0) begin errors++; $display("FAIL restart_ch0_templo: got %b want 0", nTEMPLO); end
    checks++; if (TEMP_MAX !== 13'h1E0) begin errors++; $display("FAIL restart_ch0_tmax: got %h want 1E0", TEMP_MAX); end
    checks++; if (FAULT !== 2'b00) begin errors++; $display("FAIL restart_fault: got %b want 00", FAULT); end
    waitTxn(1);
    checks++; if (nTEMPLO !== 1'b1) begin errors++; $display("FAIL restart_both_templo: got %b want 1", nTEMPLO); end
    checks++; if (TEMP_MAX !== 13'h1E0) begin errors++; $display("FAIL restart_both_tmax: got %h want 1E0", TEMP_MAX); end
  endtask

  initial begin
    TEMPSW        = 3'd3;
    FORCESTART    = 1'b0;
    sensorWord[0] = mkWord(25, 1'b1);
    sensorWord[1] = mkWord(30, 1'b1);
    test_reset();
    test_first_reads();
    test_fan_hysteresis();
    test_fault();
    test_all_float();
    test_force_start();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
